// File: rtl/instr_dispatch_if.sv
// Offer channel from the dispatcher to the instruction branches.
// The dispatcher drives the master side, and the branches answer with out_ready.
interface instr_dispatch_if #(
    parameter int N_INSTR_BRANCHES = 4,
    parameter int instr_width      = 32,
    parameter int block_width      = 8,
    parameter int COMMIT_ID_WIDTH  = 4
);
    logic [N_INSTR_BRANCHES-1:0] out_valid;
    logic [N_INSTR_BRANCHES-1:0] out_ready;
    logic [block_width-1:0]      out_block;
    logic [instr_width-1:0]      out_instr;
    logic [COMMIT_ID_WIDTH-1:0]  out_commit_id;

    modport master (output out_valid, out_block, out_instr, out_commit_id, input out_ready);
    modport slave  (input out_valid, out_block, out_instr, out_commit_id, output out_ready);
endinterface

// File: rtl/instr_dispatch.sv
// Issue side of the in-order commit path: walks the program once per sample tick,
// tags each instruction with a commit ID and offers it to its branch under credit throttling.
module instr_dispatch #(
    parameter int data_width       = 16,
    parameter int n_blocks         = 256,
    parameter int instr_width      = 32,
    parameter int max_in_flight    = 8,
    parameter int N_INSTR_BRANCHES = 4,
    parameter int COMMIT_ID_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                sample_tick,
    input  logic [$clog2(n_blocks):0]           n_blocks_active,
    output logic [$clog2(n_blocks)-1:0]         instr_addr,
    input  logic [instr_width-1:0]              instr_data,
    input  logic [$clog2(N_INSTR_BRANCHES):0]   instr_branch,
    instr_dispatch_if.master                    offer,
    input  logic [COMMIT_ID_WIDTH-1:0]          next_commit_id,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun,
    output logic [7:0]                          byte_probe
);
    localparam int BW  = $clog2(n_blocks);
    localparam int BRW = $clog2(N_INSTR_BRANCHES) + 1;
    localparam int CIW = COMMIT_ID_WIDTH;

    if (max_in_flight < 1 || max_in_flight >= (1 << COMMIT_ID_WIDTH) || data_width < 1) begin : g_param_check
        $error("instr_dispatch: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ISSUE = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                  state, state_next;
    logic [BW-1:0]           block, block_next, addr_next, oblock_next;
    logic [CIW-1:0]          issue_id, issue_id_next, ocid_next, in_flight;
    logic [N_INSTR_BRANCHES-1:0] ovalid_next;
    logic [instr_width-1:0]  oinstr_next;
    logic                    done_next, overrun_next, stall_seen, stall_next;
    logic                    last_block, is_nop, credit_ok, accept;

    // Modular difference keeps throttling correct when issue_id wraps past zero.
    assign in_flight  = issue_id - next_commit_id;
    assign credit_ok  = in_flight < CIW'(max_in_flight);
    assign last_block = ({1'b0, block} == (n_blocks_active - (BW+1)'(1)));
    assign is_nop     = instr_branch >= BRW'(N_INSTR_BRANCHES);
    assign accept     = |(offer.out_valid & offer.out_ready);

    always_comb begin
        state_next    = state;
        block_next    = block;
        addr_next     = instr_addr;
        ovalid_next   = offer.out_valid;
        oblock_next   = offer.out_block;
        oinstr_next   = offer.out_instr;
        ocid_next     = offer.out_commit_id;
        issue_id_next = issue_id;
        done_next     = 1'b0;
        overrun_next  = overrun | (sample_tick && (state != IDLE));
        stall_next    = stall_seen;
        case (state)
            IDLE: begin
                if (enable && sample_tick) begin
                    if (n_blocks_active == '0) begin
                        done_next = 1'b1;
                    end else begin
                        block_next = '0;
                        addr_next  = '0;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                if (is_nop) begin
                    if (last_block) begin
                        state_next = DRAIN;
                    end else begin
                        block_next = block + BW'(1);
                        addr_next  = block + BW'(1);
                        state_next = FETCH;
                    end
                end else if (!credit_ok) begin
                    stall_next = 1'b1;
                end else if (enable) begin
                    ovalid_next = N_INSTR_BRANCHES'(1) << instr_branch;
                    oblock_next = block;
                    oinstr_next = instr_data;
                    ocid_next   = issue_id;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    ovalid_next   = '0;
                    issue_id_next = issue_id + CIW'(1);
                    if (last_block) begin
                        state_next = DRAIN;
                    end else begin
                        block_next = block + BW'(1);
                        addr_next  = block + BW'(1);
                        state_next = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (next_commit_id == issue_id) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            block               <= '0;
            issue_id            <= '0;
            instr_addr          <= '0;
            offer.out_valid     <= '0;
            offer.out_block     <= '0;
            offer.out_instr     <= '0;
            offer.out_commit_id <= '0;
            done                <= 1'b0;
            overrun             <= 1'b0;
            stall_seen          <= 1'b0;
        end else begin
            state               <= state_next;
            block               <= block_next;
            issue_id            <= issue_id_next;
            instr_addr          <= addr_next;
            offer.out_valid     <= ovalid_next;
            offer.out_block     <= oblock_next;
            offer.out_instr     <= oinstr_next;
            offer.out_commit_id <= ocid_next;
            done                <= done_next;
            overrun             <= overrun_next;
            stall_seen          <= stall_next;
        end
    end

    assign busy       = (state != IDLE);
    assign byte_probe = {3'b000, overrun, stall_seen, state};
endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Issue side of the in-order commit path. Each sample period it walks the active program from block 0, fetches every instruction from instruction RAM, tags it with a sequential commit ID and hands it to the owning instruction branch over a valid/ready handshake. It throttles on the commit master's `next_commit_id` so that no more than `max_in_flight` instructions are ever uncommitted. It signals completion once the commit master has retired every ID it issued.

## Interface
- `data_width`, 16, sample width; carried for consistency with the core and not used internally.
- `n_blocks`, 256, program capacity; block address width is $clog2(n_blocks).
- `instr_width`, 32, instruction word width.
- `max_in_flight`, 8, maximum issued-but-uncommitted IDs; must be in 1 .. 2^`COMMIT_ID_WIDTH`-1.
- `clk` in 1: single clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: pipeline enable.
- `sample_tick` in 1: one-cycle pulse that starts a program pass.
- `n_blocks_active` in $clog2(n_blocks)+1: program length, 0..n_blocks.
- `instr_addr` out $clog2(n_blocks): registered RAM read address.
- `instr_data` in instr_width: RAM read data, valid one cycle after `instr_addr`.
- `instr_branch` in $clog2(`N_INSTR_BRANCHES`)+1: branch index, same timing as `instr_data`.
- `out_valid` out `N_INSTR_BRANCHES`: one-hot offer to a branch.
- `out_ready` in `N_INSTR_BRANCHES`: per-branch accept.
- `out_block` out $clog2(n_blocks): block index of the offered instruction.
- `out_instr` out instr_width: the offered instruction word.
- `out_commit_id` out `COMMIT_ID_WIDTH`: ID tag of the offered instruction.
- `next_commit_id` in `COMMIT_ID_WIDTH`: next ID the commit master will retire.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a pass has fully committed.
- `overrun` out 1: sticky flag; set when `sample_tick` arrives while busy.
- `byte_probe` out 8: debug bits. [2:0] = state; [3] = credit stall seen (sticky); [4] = `overrun`; [7:5] = 0.

## Operation
- Internal state: `block` (current block index) and `issue_id` (next ID to assign, `COMMIT_ID_WIDTH` bits, wraps modulo 2^W).
- In-flight count = `issue_id` − `next_commit_id`, modulo 2^W.
- FSM states: IDLE, FETCH, LOAD, ISSUE, DRAIN.
- IDLE: on `enable` && `sample_tick`:
  - if `n_blocks_active` == 0, pulse `done` and stay in IDLE;
  - otherwise set `block` = 0, drive `instr_addr` = 0 and go to FETCH.
- FETCH: wait one cycle for RAM data, then go to LOAD.
- LOAD, branch index ≥ `N_INSTR_BRANCHES` (NOP): consume no ID. If this is the last block go to DRAIN; otherwise increment `block`, drive `instr_addr` = `block`+1 and go to FETCH.
- LOAD, valid branch: stall while in-flight ≥ `max_in_flight` or `enable` = 0. Otherwise register `out_instr`, `out_block`, `out_commit_id` = `issue_id`, set `out_valid`[branch] and go to ISSUE.
- ISSUE: hold all out_* stable until `out_valid`[b] && `out_ready`[b]. On that cycle:
  - clear `out_valid`;
  - increment `issue_id`;
  - if the last block was issued (`block` == `n_blocks_active`−1) go to DRAIN; otherwise increment `block`, drive the new address and go to FETCH.
- DRAIN: when `next_commit_id` == `issue_id`, pulse `done` and go to IDLE.
- `sample_tick` outside IDLE: set `overrun` and ignore the tick; the current pass continues. `overrun` is cleared only by reset.
- `enable` low: no new offer starts and IDLE does not accept ticks. An `out_valid` already asserted stays asserted, and a handshake during enable low still completes.
- `issue_id` is never reset between passes; only reset clears it.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrating design) gives: state IDLE, `issue_id` = 0, `block` = 0, `instr_addr` = 0, `out_valid` = 0, `out_block` = 0, `out_instr` = 0, `out_commit_id` = 0, `busy` = 0, `done` = 0, `overrun` = 0, `byte_probe` = 0.
- Reset asserted mid-pass aborts immediately; `out_valid` drops in the same instant, not at a clock edge.
- Tick at edge t: `busy` = 1 and `instr_addr` valid after t; `out_valid` rises after t+2 (FETCH at t+1, LOAD at t+2).
- Minimum 3 cycles per instruction with ready held high; a NOP costs 2 cycles.
- Accept at edge t: `out_valid` = 0 after t; the next offer rises after t+2.
- Wrap: `issue_id` goes 2^W−1 → 0. In-flight arithmetic is modular, so throttling stays correct across the wrap.
- `done` rises one cycle after the edge on which `next_commit_id` == `issue_id` is sampled in DRAIN.

## Test plan
- Reset, then tick with `n_blocks_active` = 3, branches {0, 1, 0}, ready tied high → IDs 0, 1, 2 offered at cycles 2, 5, 8 after the tick. After the stub commit master advances `next_commit_id` to 3, one `done` pulse.
- `max_in_flight` = 2, `next_commit_id` frozen at 0, 5 blocks → exactly IDs 0 and 1 issued, then a LOAD stall with `byte_probe`[3] = 1. Raising `next_commit_id` to 1 releases ID 2.
- Block 1 has branch index = `N_INSTR_BRANCHES` (NOP), 3 blocks → only IDs 0 and 1 issued, for blocks 0 and 2; `done` after both commit.
- `out_ready` withheld 10 cycles with `enable` toggled during the wait → `out_valid`, `out_instr`, `out_commit_id` stable throughout; accepted on the first ready cycle.
- Preload `issue_id` near wrap (run passes until it reaches 2^W−2), 4 blocks → IDs 2^W−2, 2^W−1, 0, 1; throttle still honoured.
- Tick during DRAIN → `overrun` = 1 and sticky, pass completes normally. `n_blocks_active` = 0 tick → `done` pulse with no `out_valid`. `reset_n` low during ISSUE → all outputs 0 immediately.
